fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end; successor to the single-register pc stage.
//  Generates sequential fetch addresses and talks to imem over a req/ack handshake that tolerates wait states.
//  Buffers returned instructions with their addresses in a DEPTH-entry FIFO.
//  Decode drains the FIFO over valid/ready; an executrol jump redirects fetch and flushes all queued work.
// PARAMETERS
//  XLEN      32     instruction and address width
//  DEPTH     4      FIFO entries; power of two, >= 2
//  RESET_PC  32'h0  first fetch address after reset
//  STEP      4      address increment per sequential fetch
// PORTS
//  clk          in   1                   clock; all state updates on rising edge
//  rst          in   1                   asynchronous reset, active-high
//  jump_i       in   1                   redirect request from executrol
//  jump_addr_i  in   XLEN                redirect target
//  imem_req_o   out  1                   fetch request to imem
//  imem_addr_o  out  XLEN                fetch address; stable while imem_req_o=1
//  imem_ack_i   in   1                   imem response valid this cycle; ignored when imem_req_o=0
//  imem_inst_i  in   XLEN                fetched instruction, sampled when imem_ack_i=1
//  inst_valid_o out  1                   FIFO head valid
//  inst_o       out  XLEN                FIFO head instruction; 0 when empty
//  inst_addr_o  out  XLEN                FIFO head address; 0 when empty
//  inst_ready_i in   1                   decode accepts head; pop = inst_valid_o & inst_ready_i
//  count_o      out  $clog2(DEPTH+1)     occupied FIFO entries
// BEHAVIOUR
//  Reset values: state=IDLE, fetch_pc=RESET_PC, FIFO empty.
//   Outputs at reset: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_addr_o=0, count_o=0.
//  At most one request outstanding. imem_req_o=1 exactly in WAIT or DROP.
//  imem_addr_o is driven from a register; it changes only on a state transition.
//  FSM:
//   IDLE: count<DEPTH -> WAIT (addr=fetch_pc); otherwise stay.
//   WAIT, ack, no jump: push {imem_inst_i, fetch_pc}; fetch_pc+=STEP.
//    next_count = count+1-pop.
//    If next_count<DEPTH -> WAIT at new fetch_pc (back-to-back issue); else -> IDLE.
//   WAIT, no ack, no jump: hold; req and addr unchanged.
//   WAIT, jump & ack: drop the response; FIFO cleared; fetch_pc=jump_addr_i; -> WAIT at jump_addr_i.
//   WAIT, jump, no ack: FIFO cleared; fetch_pc=jump_addr_i.
//    -> DROP; req stays high with the old addr (protocol: a request is never withdrawn).
//   DROP, ack: discard the data; -> WAIT at fetch_pc.
//   DROP, no ack: hold. A jump in DROP only updates fetch_pc.
//   IDLE, jump: FIFO cleared; fetch_pc=jump_addr_i; -> WAIT at jump_addr_i next cycle.
//  Jump priority: jump_i overrides pop and push in the same cycle. FIFO is empty the cycle after.
//  Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
//  Full (count==DEPTH): no new request issued; pop frees a slot and fetch restarts the next cycle.
//  Empty with pop attempt: no effect (inst_valid_o=0).
//  Address arithmetic: fetch_pc+STEP wraps modulo 2^XLEN, no flag.
//  Latency: zero-wait ack pushes at the edge; the entry is visible on inst_* in the following cycle.
//   Sustained throughput is 1 instruction/cycle.
//  Mid-operation reset: asynchronous. All state, outputs and FIFO contents return to reset values at once.
//   Any in-flight imem response is ignored.
// TESTING
//  1 Reset release, ack tied 1, ready=1.
//    -> req=1 cycle 1 addr 0x0; inst_addr_o = 0x0,0x4,0x8... one per cycle.
//  2 ready=0, ack=1, DEPTH=4.
//    -> 4 pushes (addr 0x0-0xC); count_o=4; req=0.
//    -> ready pulse 1 cycle: count=3, then req=1 addr 0x10.
//  3 ack delayed 3 cycles.
//    -> imem_addr_o held at 0x0 with req=1 for all 4 cycles; exactly one push.
//  4 jump_i=1 target 0x100 while WAIT, no ack, FIFO holding 2 entries.
//    -> count_o=0 next cycle; req held at old addr until ack.
//    -> that data discarded; next req addr 0x100.
//  5 jump with ack in the same cycle, target 0x200.
//    -> no push; next req addr 0x200; first inst_addr_o seen is 0x200.
//  6 rst asserted mid-burst with count=3.
//    -> outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch with imem req/ack handshake and DEPTH-entry decode FIFO
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              STEP     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_i,
    input  logic [XLEN-1:0]            jump_addr_i,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [XLEN-1:0]            imem_inst_i,
    output logic                       inst_valid_o,
    output logic [XLEN-1:0]            inst_o,
    output logic [XLEN-1:0]            inst_addr_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int              PW     = $clog2(DEPTH);
    localparam int              CW     = $clog2(DEPTH+1);
    localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            push, pop, flush;
    logic [CW-1:0]   count_q, next_count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] addr_mem [DEPTH];

    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o & inst_ready_i;
    assign imem_req_o   = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr_o  = addr_q;
    assign count_o      = count_q;
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : '0;
    assign inst_addr_o  = inst_valid_o ? addr_mem[rd_ptr] : '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        next_count = count_q + CW'(1) - CW'(pop);
        case (state_q)
            IDLE: begin
                if (jump_i) begin
                    flush   = 1'b1;
                    pc_d    = jump_addr_i;
                    addr_d  = jump_addr_i;
                    state_d = WAIT;
                end else if (count_q < FULL) begin
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (jump_i) begin
                    flush = 1'b1;
                    pc_d  = jump_addr_i;
                    // Without an ack the old request must stay up until imem answers it.
                    if (imem_ack_i) begin
                        addr_d = jump_addr_i;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack_i) begin
                    push = 1'b1;
                    pc_d = pc_q + STEP_V;
                    if (next_count < FULL) begin
                        addr_d = pc_q + STEP_V;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (jump_i) begin
                    flush = 1'b1;
                    pc_d  = jump_addr_i;
                end
                if (imem_ack_i) begin
                    addr_d  = pc_d;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    inst_mem[wr_ptr] <= imem_inst_i;
                    addr_mem[wr_ptr] <= pc_q;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
